// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - ALU control codes, alu_op encodings and funct values shared by ID/EX users
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational alu_op/funct to 4-bit ALU control decode
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    unique case (alu_op_i)
      OP_ADD: alu_ctrl_o = ALU_ADD;
      OP_SUB: alu_ctrl_o = ALU_SUB;
      OP_OR:  alu_ctrl_o = ALU_OR;
      OP_RTYPE: begin
        // Unknown funct values fall back to add so a bad encoding stays harmless
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_NOR:  alu_ctrl_o = ALU_NOR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode, operand forwarding and load-use stall
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d, dec_ctrl;
  logic              alu_src_q, alu_src_d;
  logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic              id_uses_rt, bubble;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op_i   (id_alu_op),
    .funct_i    (id_funct),
    .alu_ctrl_o (dec_ctrl)
  );

  // Immediate-form instructions only read rt when it is store data
  assign id_uses_rt = ~id_alu_src | id_mem_write;
  assign stall = mem_read_q & (dest_q != '0)
               & ((dest_q == id_rs) | ((dest_q == id_rt) & id_uses_rt)) & ~flush;
  assign bubble = stall | flush;

  always_comb begin
    rs_data_d = id_rs_data;
    rt_data_d = id_rt_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs)) rs_data_d = wb_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt)) rt_data_d = wb_data;
    imm_d        = id_imm;
    rs_d         = id_rs;
    rt_d         = id_rt;
    dest_d       = id_reg_dst ? id_rd : id_rt;
    alu_src_d    = id_alu_src;
    alu_ctrl_d   = bubble ? ALU_ADD : dec_ctrl;
    reg_write_d  = id_reg_write  & ~bubble;
    mem_read_d   = id_mem_read   & ~bubble;
    mem_write_d  = id_mem_write  & ~bubble;
    mem_to_reg_d = id_mem_to_reg & ~bubble;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  // EX/MEM result is newer than MEM/WB, so it wins when both match
  always_comb begin
    fwd_rs = rs_data_q;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs_q))    fwd_rs = exm_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_q))  fwd_rs = wb_data;
    fwd_rt = rt_data_q;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rt_q))    fwd_rt = exm_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_q))  fwd_rt = wb_data;
  end

  assign alu_in1       = fwd_rs;
  assign alu_in2       = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with directed vectors
module tb_id_ex_stage;

  logic        clk, rst_n;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_data;
  logic        stall;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  localparam int S_STALL = 0, S_IN1 = 1, S_IN2 = 2, S_ALUC = 3, S_SD = 4, S_DEST = 5, S_CTL = 6;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_STALL: return {31'd0, stall};
      S_IN1:   return alu_in1;
      S_IN2:   return alu_in2;
      S_ALUC:  return {28'd0, alu_ctrl};
      S_SD:    return ex_store_data;
      S_DEST:  return {27'd0, ex_dest};
      default: return {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    endcase
  endfunction

  // Monitor: samples on the falling edge, retires every expectation that is due
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        act = actual(sb[i].sel);
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int off, input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.due = cyc + off; e.sel = sel; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_alu_op = 2'b00; id_funct = '0;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    flush = 0;
    exm_reg_write = 0; exm_rd = '0; exm_result = '0;
    wb_reg_write = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic lw_r8();
    idle();
    id_rs = 5'd1; id_rt = 5'd8; id_alu_src = 1; id_imm = 32'd4;
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
  endtask

  task automatic add_r9_r8_r1();
    idle();
    id_rs = 5'd8; id_rt = 5'd1; id_rd = 5'd9; id_reg_dst = 1;
    id_alu_op = 2'b10; id_funct = 6'h20; id_reg_write = 1;
    id_rs_data = 32'h0; id_rt_data = 32'h5;
  endtask

  logic [5:0] fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
  logic [3:0] ac_tab [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0010};

  initial begin
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    push(0, S_CTL, 32'h0, "rst_ctl");
    push(0, S_ALUC, 32'h2, "rst_aluc");
    push(0, S_STALL, 32'h0, "rst_stall");
    push(0, S_DEST, 32'h0, "rst_dest");
    push(0, S_IN1, 32'h0, "rst_in1");
    push(0, S_IN2, 32'h0, "rst_in2");
    push(0, S_SD, 32'h0, "rst_sd");
    step(); rst_n = 1;

    // Asynchronous reset while a sub instruction sits in the register
    step(); idle(); id_alu_op = 2'b01; id_reg_write = 1; id_rd = 5'd7; id_reg_dst = 1;
    push(1, S_ALUC, 32'h6, "sub_dec");
    push(1, S_CTL, 32'h8, "sub_ctl");
    push(1, S_DEST, 32'h7, "sub_dest");
    step();
    step(); rst_n = 0;
    push(0, S_CTL, 32'h0, "async_rst_ctl");
    push(0, S_ALUC, 32'h2, "async_rst_aluc");
    push(0, S_DEST, 32'h0, "async_rst_dest");
    step(); rst_n = 1; idle();

    for (int i = 0; i < 7; i++) begin
      step(); idle(); id_alu_op = 2'b10; id_funct = fn_tab[i];
      push(1, S_ALUC, {28'd0, ac_tab[i]}, $sformatf("dec_funct_%h", fn_tab[i]));
    end
    step(); idle(); id_alu_op = 2'b11;
    push(1, S_ALUC, 32'h1, "dec_op_or");

    // Forwarding priority on rs=5
    step(); idle(); id_rs = 5'd5; id_rs_data = 32'h99; id_reg_write = 1;
    step(); exm_reg_write = 1; exm_rd = 5'd5; exm_result = 32'h11;
    wb_reg_write = 1; wb_rd = 5'd5; wb_data = 32'h22;
    push(0, S_IN1, 32'h11, "fwd_exm_prio");
    step(); exm_reg_write = 0;
    push(0, S_IN1, 32'h22, "fwd_wb");
    step(); exm_reg_write = 1; exm_rd = 5'd0; exm_result = 32'h11; wb_reg_write = 0;
    push(0, S_IN1, 32'h22, "fwd_exm_r0");
    step(); exm_reg_write = 0; wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'h33;
    push(0, S_IN1, 32'h99, "fwd_wb_r0");
    step(); idle(); id_alu_src = 1; id_imm = 32'h1234; id_rt = 5'd5; id_rt_data = 32'h77;
    push(1, S_IN2, 32'h1234, "imm_sel");
    push(1, S_SD, 32'h77, "sd_plain");

    // Load-use: lw r8 then add r9,r8,r1
    step(); lw_r8();
    push(1, S_CTL, 32'hD, "lw_ctl");
    push(1, S_DEST, 32'h8, "lw_dest");
    step(); add_r9_r8_r1();
    push(0, S_STALL, 32'h1, "lu_stall");
    step(); add_r9_r8_r1();
    push(0, S_STALL, 32'h0, "lu_stall_clear");
    push(0, S_CTL, 32'h0, "lu_bubble");
    push(0, S_ALUC, 32'h2, "lu_bubble_aluc");
    step(); idle(); wb_reg_write = 1; wb_rd = 5'd8; wb_data = 32'hABC;
    push(0, S_IN1, 32'hABC, "lu_fwd_rs");
    push(0, S_IN2, 32'h5, "lu_rt");
    push(0, S_CTL, 32'h8, "lu_add_ctl");
    push(0, S_DEST, 32'h9, "lu_add_dest");
    push(0, S_STALL, 32'h0, "lu_no_stall");

    // Immediate instruction reading only rs does not stall on rt match
    step(); lw_r8();
    step(); idle(); id_rt = 5'd8; id_alu_src = 1; id_reg_write = 1;
    push(0, S_STALL, 32'h0, "lu_imm_rt_nostall");

    // Flush together with a hazard
    step(); lw_r8();
    step(); add_r9_r8_r1(); flush = 1;
    push(0, S_STALL, 32'h0, "flush_nostall");
    step(); idle();
    push(0, S_CTL, 32'h0, "flush_bubble");
    push(0, S_ALUC, 32'h2, "flush_aluc");

    // Write-through: sw r3 while WB writes r3
    step(); idle(); id_rt = 5'd3; id_alu_src = 1; id_mem_write = 1; id_imm = 32'd8;
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    push(1, S_SD, 32'hDEAD, "wt_store");
    push(1, S_CTL, 32'h2, "sw_ctl");
    push(1, S_IN2, 32'h8, "sw_imm");
    step(); idle();

    // Reset while the stall would be raised
    step(); lw_r8();
    step(); add_r9_r8_r1(); rst_n = 0;
    push(0, S_STALL, 32'h0, "rst_midstall");
    step(); rst_n = 1; add_r9_r8_r1();
    step(); idle();
    push(0, S_CTL, 32'h8, "post_rst_ctl");
    push(0, S_DEST, 32'h9, "post_rst_dest");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage sitting directly upstream of the ALU: registers decoded operands and control from the decode stage, resolves the 4-bit ALU control code, and drives the ALU's two 32-bit operands through EX/MEM and MEM/WB forwarding muxes. It also detects load-use hazards, requests a one-cycle stall of PC and IF/ID, and inserts bubbles on stall or flush.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register-address width
- clk  in  1  rising-edge clock (one clock domain)
- rst_n  in  1  asynchronous, active-low reset
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW  source/destination register numbers
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or
- id_funct  in  6  instruction funct field
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  decode control
- flush  in  1  squash instruction being captured (taken branch/jump)
- exm_reg_write  in  1, exm_rd  in  REG_AW, exm_result  in  DATA_W  EX/MEM forwarding source
- wb_reg_write  in  1, wb_rd  in  REG_AW, wb_data  in  DATA_W  MEM/WB forwarding source
- stall  out  1  hold PC and IF/ID this cycle
- alu_in1, alu_in2  out  DATA_W  ALU operands (after forwarding)
- alu_ctrl  out  4  ALU control code
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_dest  out  REG_AW  destination register (rd or rt per reg_dst)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control

## Operation
- ALU decode (registered): alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001; 10 -> funct 100000 0010, 100010 0110, 100100 0000, 100101 0001, 100111 1100, 101010 0111; any other funct -> 0010.
- Capture: on each rising edge with stall=0 and flush=0, register all id_* fields, decoded alu_ctrl, and ex_dest = id_reg_dst ? id_rd : id_rt.
- Write-through on capture: if wb_reg_write, wb_rd != 0 and wb_rd == id_rs (id_rt), capture wb_data instead of id_rs_data (id_rt_data).
- Bubble: on stall=1 or flush=1, clear ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg; data/address fields don't-care; alu_ctrl := 0010.
- Load-use hazard: stall = ex_mem_read & (ex_dest != 0) & (ex_dest == id_rs | (ex_dest == id_rt & id_uses_rt)) & ~flush, where id_uses_rt = ~id_alu_src | id_mem_write.
- Forwarding (combinational, per registered operand rs/rt): if exm_reg_write, exm_rd != 0, exm_rd == reg -> exm_result; else if wb_reg_write, wb_rd != 0, wb_rd == reg -> wb_data; else registered value. EX/MEM has priority.
- alu_in1 = forwarded rs; alu_in2 = ex_alu_src ? registered imm : forwarded rt; ex_store_data = forwarded rt always.
- Register 0 is never a forwarding/hazard match.

## Timing
- Latency: id_* to alu_in*/alu_ctrl: 1 cycle. Forwarding and stall: combinational, same cycle.
- Reset (async assert, sync-safe release): all registered state 0, i.e. control outputs 0, ex_dest 0, alu_ctrl 0010, alu_in1/alu_in2/ex_store_data 0 with forwarding sources inactive; stall 0.
- Stall lasts exactly one cycle per load-use: next cycle holds a bubble, so the condition self-clears.
- flush and stall together: flush wins, stall=0, bubble inserted.
- Reset mid-stall: stall drops immediately with rst_n low; first post-reset capture is normal.

## Structure
- Package mips_pkg: ALU control constants (ALU_ADD 0010, ALU_SUB 0110, ALU_AND 0000, ALU_OR 0001, ALU_NOR 1100, ALU_SLT 0111), alu_op codes, funct constants.
- Sub-module alu_ctrl_dec: combinational alu_op/funct -> 4-bit code, reused by any later ALU-control user.

## Test plan
- Reset: rst_n low mid-cycle -> all control outputs 0, alu_ctrl 0010, stall 0 asynchronously.
- Decode sweep: alu_op 10 with each funct (20,22,24,25,27,2A hex), plus 3F -> alu_ctrl 0010,0110,0000,0001,1100,0111,0010 one cycle later.
- Forward priority: captured rs=5; exm_rd=5 result 0x11, wb_rd=5 data 0x22 -> alu_in1 0x11; drop exm_reg_write -> 0x22; exm_rd=0 never forwards.
- Load-use: lw into r8, next instr add r9,r8,r1 -> stall=1 one cycle, bubble (all control 0), then add captured, r8 forwarded from wb_data.
- Flush+hazard: same load-use with flush=1 -> stall=0, bubble captured.
- Write-through: wb writes r3=0xDEAD while id_rt=3 captures stale 0 -> ex stage rt value 0xDEAD (ex_store_data 0xDEAD on sw).
